// File: rtl/counter_pkg.sv
// counter_pkg: shared state type and default sizing for counter_split.
package counter_pkg;
    localparam int W_DEF     = 4;
    localparam int B_MAX_DEF = 4;
    typedef enum logic [1:0] {IDLE, DOWN_BOTH, DOWN_A, DONE} state_t;
endpackage

// File: rtl/down_counter.sv
// down_counter: loadable down-counter that never steps below zero.
module down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q, q_d;
    always_comb q_d = load ? load_val : (dec && q_q != '0) ? q_q - 1'b1 : q_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) q_q <= '0;
        else        q_q <= q_d;
    assign q = q_q;
endmodule

// File: rtl/counter_split.sv
// counter_split: splits a loaded sum into A and B shares (B capped at B_MAX)
// and counts both down, B alongside A first, then A alone.
import counter_pkg::*;
module counter_split #(
    parameter int W     = W_DEF,
    parameter int B_MAX = B_MAX_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_w,
    input  logic [W-1:0] q_in,
    output logic         ready,
    output logic [W-1:0] a_out,
    output logic [W-1:0] b_out,
    output logic         cnt_a,
    output logic         cnt_b,
    output logic         done
);
    localparam logic [W-1:0] BM = W'(B_MAX);
    state_t state_q, state_d;
    logic [W-1:0] half, b_ld, a_ld;
    logic load;
    // a_ld >= b_ld always holds, so A is never zero while B still counts
    assign half  = q_in >> 1;
    assign b_ld  = (half > BM) ? BM : half;
    assign a_ld  = q_in - b_ld;
    assign ready = state_q == IDLE;
    assign load  = ready && load_w;
    assign cnt_b = state_q == DOWN_BOTH && b_out != '0;
    assign cnt_a = cnt_b || (state_q == DOWN_A && a_out != '0);
    assign done  = state_q == DONE;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = load ? DOWN_BOTH : IDLE;
            DOWN_BOTH: state_d = (b_out == '0) ? DOWN_A : DOWN_BOTH;
            DOWN_A:    state_d = (a_out == '0) ? DONE : DOWN_A;
            default:   state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    down_counter #(.W(W)) u_a (
        .clk(clk), .reset(reset), .load(load), .load_val(a_ld), .dec(cnt_a), .q(a_out)
    );
    down_counter #(.W(W)) u_b (
        .clk(clk), .reset(reset), .load(load), .load_val(b_ld), .dec(cnt_b), .q(b_out)
    );
endmodule

// File: tb/tb_counter_split.sv
// tb_counter_split: table-driven loads with a scoreboard queue, plus hand-written
// sequences for busy-time loads, mid-count reset and load after reset.
module tb_counter_split;
    logic clk = 0, reset = 1, load_w = 0;
    logic [3:0] q_in = 0;
    logic ready, cnt_a, cnt_b, done;
    logic [3:0] a_out, b_out;
    int n_cmp = 0, n_bad = 0;

    typedef struct { int q; int a; int b; int busy; } vec_t;
    vec_t exp_q[$];
    vec_t tbl[8];

    counter_split #(.W(4), .B_MAX(4)) dut (
        .clk(clk), .reset(reset), .load_w(load_w), .q_in(q_in), .ready(ready),
        .a_out(a_out), .b_out(b_out), .cnt_a(cnt_a), .cnt_b(cnt_b), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // expected {a, b, {cnt_a,cnt_b,done}} at the i-th sample after the accepting edge
    function automatic void exp_at(input int i, input int a0, input int b0,
                                   output int ea, output int eb, output int ef);
        int j;
        if (i <= b0 + 1) begin
            ea = a0 - (i - 1); eb = b0 - (i - 1); ef = (i <= b0) ? 6 : 0;
        end else if (i <= a0 + 2) begin
            j = i - b0 - 1;
            ea = a0 - b0 - (j - 1); eb = 0; ef = (j <= a0 - b0) ? 4 : 0;
        end else begin
            ea = 0; eb = 0; ef = 1;
        end
    endfunction

    task automatic start(input vec_t v);
        @(negedge clk);
        chk("ready_before_load", ready, 1);
        load_w = 1; q_in = v.q[3:0];
        exp_q.push_back(v);
    endtask

    // follows one countdown; optionally raises a load of inj_q at sample inj_at and holds it
    task automatic follow(input int inj_at, input vec_t inj);
        vec_t e;
        int ea, eb, ef;
        @(negedge clk);
        load_w = 0;
        e = exp_q.pop_front();
        chk($sformatf("sum_q%0d", e.q), 32'(a_out) + 32'(b_out), e.q);
        for (int i = 1; i <= e.busy; i++) begin
            exp_at(i, e.a, e.b, ea, eb, ef);
            chk($sformatf("ready_q%0d_c%0d", e.q, i), ready, 0);
            chk($sformatf("a_q%0d_c%0d", e.q, i), a_out, ea);
            chk($sformatf("b_q%0d_c%0d", e.q, i), b_out, eb);
            chk($sformatf("flags_q%0d_c%0d", e.q, i), {cnt_a, cnt_b, done}, ef);
            if (i == inj_at) begin
                load_w = 1; q_in = inj.q[3:0];
                exp_q.push_back(inj);
            end
            @(negedge clk);
        end
        chk($sformatf("ready_back_q%0d", e.q), ready, 1);
        chk($sformatf("done_clear_q%0d", e.q), done, 0);
    endtask

    initial begin
        vec_t none, v;
        none = '{0, 0, 0, 0};
        tbl[0] = '{13,  9, 4, 12};
        tbl[1] = '{ 0,  0, 0,  3};
        tbl[2] = '{15, 11, 4, 14};
        tbl[3] = '{ 1,  1, 0,  4};
        tbl[4] = '{ 6,  3, 3,  6};
        tbl[5] = '{ 9,  5, 4,  8};
        tbl[6] = '{ 2,  1, 1,  4};
        tbl[7] = '{ 7,  4, 3,  7};

        #1 reset = 0;
        #2;
        chk("rst_ready", ready, 1);
        chk("rst_a", a_out, 0);
        chk("rst_b", b_out, 0);
        chk("rst_flags", {cnt_a, cnt_b, done}, 0);
        load_w = 1; q_in = 5;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_load_ignored_ready", ready, 1);
        chk("rst_load_ignored_a", a_out, 0);
        @(negedge clk);
        load_w = 0; reset = 1;

        foreach (tbl[k]) begin
            start(tbl[k]);
            follow(0, none);
        end

        // a load raised while busy is held off until ready rises
        start('{6, 3, 3, 6});
        follow(2, '{9, 5, 4, 8});
        follow(0, none);

        // reset in DOWN_A with a=3 clears immediately and suppresses done
        start('{13, 9, 4, 12});
        @(negedge clk);
        load_w = 0;
        v = exp_q.pop_front();
        repeat (7) @(negedge clk);
        chk("pre_rst_a", a_out, 3);
        chk("pre_rst_b", b_out, 0);
        chk("pre_rst_flags", {cnt_a, cnt_b, done}, 4);
        reset = 0;
        #1;
        chk("mid_rst_a", a_out, 0);
        chk("mid_rst_b", b_out, 0);
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_flags", {cnt_a, cnt_b, done}, 0);
        @(negedge clk);
        chk("mid_rst_hold_ready", ready, 1);
        // first load after reset release is taken on the very next edge
        reset = 1; load_w = 1; q_in = 1;
        exp_q.push_back('{1, 1, 0, 4});
        follow(0, none);
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
